// File: rtl/apb_slave_regfile.sv
// APB completer backed by a local register bank.
// Register 0 is a read-only ID word; the rest are plain read/write storage.
// Wait states and error responses are generated from the latched setup-phase address.
module apb_slave_regfile #(
    parameter int unsigned             ADDR_WIDTH  = 32,
    parameter int unsigned             DATA_WIDTH  = 32,
    parameter int unsigned             SLV_COUNT   = 4,
    parameter int unsigned             SLV_IDX     = 0,
    parameter int unsigned             REG_COUNT   = 16,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned             WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0]   ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [SLV_COUNT-1:0]  PSEL,
    input  logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int unsigned IDXW = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    pready_q, pready_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]   regs_d [REG_COUNT];

    logic                    sel;
    logic                    enter_done;
    logic                    rsp_err;
    logic [IDXW-1:0]         rsp_idx;
    logic                    cur_err;
    logic [IDXW-1:0]         cur_idx;
    logic                    unused_psel;

    assign sel         = PSEL[SLV_IDX];
    assign unused_psel = ^PSEL;

    // Error when outside the block window, misaligned, or writing the read-only ID register.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a, input logic wr);
        logic hit;
        logic aligned;
        logic ro;
        hit     = (a[ADDR_WIDTH-1:IDXW+2] == BASE_ADDR[ADDR_WIDTH-1:IDXW+2]);
        aligned = (a[1:0] == 2'b00);
        ro      = wr && (a[IDXW+1:2] == '0);
        return !hit || !aligned || ro;
    endfunction

    // Decode of the transfer held in the latch, used when committing a write.
    assign cur_err = addr_err(addr_q, write_q);
    assign cur_idx = addr_q[IDXW+1:2];

    // Decode of the transfer as it will be latched; the zero-wait path enters DONE
    // in the same edge that captures the setup phase, so the response looks through.
    assign rsp_err = addr_err(addr_d, write_d);
    assign rsp_idx = addr_d[IDXW+1:2];

    // Next-state, response and register-bank update logic.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        pready_d   = 1'b0;
        prdata_d   = '0;
        pslverr_d  = 1'b0;
        regs_d     = regs_q;
        enter_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (sel && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    wcnt_d  = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!sel) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!sel) begin
                    state_d = S_IDLE;
                end else if (PENABLE) begin
                    if (write_q && !cur_err) begin
                        regs_d[cur_idx] = wdata_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    pready_d  = pready_q;
                    prdata_d  = prdata_q;
                    pslverr_d = pslverr_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_done) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            if (!write_d && !rsp_err) begin
                prdata_d = (rsp_idx == '0) ? ID_VALUE : regs_q[rsp_idx];
            end
        end
    end

    // State, latched transfer, registered outputs and register bank.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            regs_q    <= regs_d;
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two completers on one APB bus (PSEL[0] zero-wait,
// PSEL[1] three wait states), a timestamp-based behavioural model checked on every
// cycle, and directed transfers with literal expected results.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        clk;
    logic        rst;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        penable;
    logic [3:0]  psel;

    logic        pready0, pslverr0, pready1, pslverr1;
    logic [31:0] prdata0, prdata1;

    int vectors     = 0;
    int miscompares = 0;

    apb_slave_regfile #(
        .SLV_IDX     (0),
        .WAIT_CYCLES (0)
    ) u_dut0 (
        .PCLK    (clk),
        .PRESET  (rst),
        .PADDR   (paddr),
        .PWRITE  (pwrite),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWDATA  (pwdata),
        .PREADY  (pready0),
        .PRDATA  (prdata0),
        .PSLVERR (pslverr0)
    );

    apb_slave_regfile #(
        .SLV_IDX     (1),
        .WAIT_CYCLES (3)
    ) u_dut1 (
        .PCLK    (clk),
        .PRESET  (rst),
        .PADDR   (paddr),
        .PWRITE  (pwrite),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWDATA  (pwdata),
        .PREADY  (pready1),
        .PRDATA  (prdata1),
        .PSLVERR (pslverr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          wait_of [2] = '{0, 3};
    int          edge_n;
    bit          m_act   [2];
    int          m_setup [2];
    bit          m_wr    [2];
    bit          m_err   [2];
    int          m_idx   [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_mem   [2][16];

    // A transfer is open from its setup edge until completion/abort; PREADY is
    // expected once wait_of edges have elapsed since setup.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_n = 0;
            for (int s = 0; s < 2; s++) begin
                m_act[s] = 0;
                for (int r = 0; r < 16; r++) m_mem[s][r] = '0;
            end
        end else begin
            edge_n++;
            for (int s = 0; s < 2; s++) begin
                if (m_act[s]) begin
                    if (!psel[s]) begin
                        m_act[s] = 0;
                    end else if (penable && (edge_n - m_setup[s]) >= wait_of[s] + 1) begin
                        if (m_wr[s] && !m_err[s]) m_mem[s][m_idx[s]] = m_wdata[s];
                        m_act[s] = 0;
                    end
                end else if (psel[s] && !penable) begin
                    bit hit;
                    bit al;
                    hit        = (paddr >= 32'h1000) && (paddr < 32'h1040);
                    al         = (paddr % 4) == 0;
                    m_idx[s]   = hit ? int'((paddr - 32'h1000) / 4) : 0;
                    m_wr[s]    = pwrite;
                    m_wdata[s] = pwdata;
                    m_err[s]   = !hit || !al || (pwrite && m_idx[s] == 0);
                    if (pwrite || m_err[s]) m_rdata[s] = '0;
                    else if (m_idx[s] == 0) m_rdata[s] = ID;
                    else m_rdata[s] = m_mem[s][m_idx[s]];
                    m_act[s]   = 1;
                    m_setup[s] = edge_n;
                end
            end
        end
    end

    // Every-cycle comparison of both completers against the model.
    always @(negedge clk) begin
        bit rdy0;
        bit rdy1;
        rdy0 = m_act[0] && (edge_n - m_setup[0]) >= wait_of[0];
        rdy1 = m_act[1] && (edge_n - m_setup[1]) >= wait_of[1];
        chk("s0_pready",  {31'b0, pready0},  {31'b0, rdy0});
        chk("s0_prdata",  prdata0,           rdy0 ? m_rdata[0] : 32'h0);
        chk("s0_pslverr", {31'b0, pslverr0}, {31'b0, rdy0 && m_err[0]});
        chk("s1_pready",  {31'b0, pready1},  {31'b0, rdy1});
        chk("s1_prdata",  prdata1,           rdy1 ? m_rdata[1] : 32'h0);
        chk("s1_pslverr", {31'b0, pslverr1}, {31'b0, rdy1 && m_err[1]});
    end

    // ---------------- stimulus ----------------
    function automatic logic rdy_of(input int s);
        return (s == 0) ? pready0 : pready1;
    endfunction

    function automatic logic [31:0] dat_of(input int s);
        return (s == 0) ? prdata0 : prdata1;
    endfunction

    function automatic logic err_of(input int s);
        return (s == 0) ? pslverr0 : pslverr1;
    endfunction

    // Called #1 after an edge; returns #1 after the completion edge with the bus still driven.
    task automatic xfer(input int s, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        psel    = '0;
        psel[s] = 1'b1;
        paddr   = a;
        pwrite  = wr;
        pwdata  = wd;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0;
        while (!rdy_of(s) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = dat_of(s);
        er = err_of(s);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        #2;
        chk("rst_pready0", {31'b0, pready0}, 32'h0);
        chk("rst_prdata0", prdata0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // zero-wait ID read
        xfer(0, 32'h1000, 1'b0, '0, rd, er, lat);
        chk("id_rdata", rd, ID);
        chk("id_err", {31'b0, er}, 32'h0);
        chk("id_lat", 32'(lat), 32'd0);
        idle();

        // three-wait write and readback
        xfer(1, 32'h1008, 1'b1, 32'hDEAD_BEEF, rd, er, lat);
        chk("w3_lat", 32'(lat), 32'd3);
        chk("w3_err", {31'b0, er}, 32'h0);
        idle();
        xfer(1, 32'h1008, 1'b0, '0, rd, er, lat);
        chk("r3_lat", 32'(lat), 32'd3);
        chk("r3_rdata", rd, 32'hDEAD_BEEF);
        chk("r3_err", {31'b0, er}, 32'h0);
        idle();

        // error responses
        xfer(0, 32'h1000, 1'b1, 32'h1111_2222, rd, er, lat);
        chk("err_wr_id", {31'b0, er}, 32'h1);
        chk("err_wr_id_data", rd, 32'h0);
        xfer(0, 32'h1002, 1'b0, '0, rd, er, lat);
        chk("err_misalign", {31'b0, er}, 32'h1);
        chk("err_misalign_data", rd, 32'h0);
        xfer(0, 32'h2000, 1'b0, '0, rd, er, lat);
        chk("err_miss", {31'b0, er}, 32'h1);
        chk("err_miss_data", rd, 32'h0);
        xfer(0, 32'h1000, 1'b0, '0, rd, er, lat);
        chk("id_after_err", rd, ID);
        chk("id_after_err_e", {31'b0, er}, 32'h0);

        // back-to-back write then read, no idle cycle
        xfer(0, 32'h1004, 1'b1, 32'h1234_5678, rd, er, lat);
        xfer(0, 32'h1004, 1'b0, '0, rd, er, lat);
        chk("b2b0_rdata", rd, 32'h1234_5678);
        xfer(1, 32'h103C, 1'b1, 32'h0BAD_F00D, rd, er, lat);
        xfer(1, 32'h103C, 1'b0, '0, rd, er, lat);
        chk("b2b1_rdata", rd, 32'h0BAD_F00D);
        idle();

        // PSEL[1] transfer must not touch slave 0
        xfer(1, 32'h1004, 1'b1, 32'hCAFE_F00D, rd, er, lat);
        idle();
        xfer(0, 32'h1004, 1'b0, '0, rd, er, lat);
        chk("s0_untouched", rd, 32'h1234_5678);
        xfer(1, 32'h1004, 1'b0, '0, rd, er, lat);
        chk("s1_written", rd, 32'hCAFE_F00D);
        idle();

        // PENABLE without a setup phase is ignored
        psel = 4'b0001; penable = 1'b1; paddr = 32'h1000;
        repeat (3) begin @(posedge clk); #1; end
        chk("no_setup_pready", {31'b0, pready0}, 32'h0);
        idle();

        // PSEL dropped during WAIT aborts the write
        psel = 4'b0010; paddr = 32'h1010; pwrite = 1'b1; pwdata = 32'h55AA_55AA; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(1, 32'h1010, 1'b0, '0, rd, er, lat);
        chk("abort_nowrite", rd, 32'h0);
        idle();

        // reset in WAIT of a write
        xfer(1, 32'h100C, 1'b1, 32'h7777_8888, rd, er, lat);
        idle();
        psel = 4'b0010; paddr = 32'h100C; pwrite = 1'b1; pwdata = 32'h9999_AAAA; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rstw_pready", {31'b0, pready1}, 32'h0);
        chk("rstw_prdata", prdata1, 32'h0);
        psel = '0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        xfer(1, 32'h100C, 1'b0, '0, rd, er, lat);
        chk("rstw_reg_clear", rd, 32'h0);
        xfer(1, 32'h1008, 1'b0, '0, rd, er, lat);
        chk("rstw_other_clear", rd, 32'h0);
        idle();

        // reset while PREADY is high
        psel = 4'b0001; paddr = 32'h1000; pwrite = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("rstd_pready_pre", {31'b0, pready0}, 32'h1);
        chk("rstd_prdata_pre", prdata0, ID);
        penable = 1'b1; rst = 1'b1;
        #1;
        chk("rstd_pready", {31'b0, pready0}, 32'h0);
        chk("rstd_prdata", prdata0, 32'h0);
        psel = '0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        xfer(0, 32'h1004, 1'b0, '0, rd, er, lat);
        chk("rstd_reg_clear", rd, 32'h0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that terminates the master-side transfers of the shared APB bus and serves them from a local register bank. It decodes one bit of the bus PSEL vector, inserts a parameterised number of wait states, and flags illegal accesses with PSLVERR. It is the slave-end counterpart used by the bus VIP environment as the reference DUT and as a behavioural endpoint model.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width; register width
- SLV_COUNT, 4, width of the PSEL vector on the bus
- SLV_IDX, 0, which PSEL bit selects this block (0..SLV_COUNT-1)
- REG_COUNT, 16, number of registers; power of two, >= 2
- BASE_ADDR, 32'h0000_1000, base byte address; aligned to REG_COUNT*4
- WAIT_CYCLES, 0, wait states per transfer (0..15)
- ID_VALUE, 32'hA9B0_0001, constant read value of register 0

Ports:
- PCLK  in  1  bus clock; all state updates on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PADDR  in  ADDR_WIDTH  byte address
- PWRITE  in  1  1 = write, 0 = read
- PSEL  in  SLV_COUNT  one-hot select; only PSEL[SLV_IDX] is used
- PENABLE  in  1  access-phase indicator
- PWDATA  in  DATA_WIDTH  write data
- PREADY  out  1  transfer completion, registered
- PRDATA  out  DATA_WIDTH  read data, registered
- PSLVERR  out  1  error response, valid only with PREADY=1, registered

## Operation
- sel = PSEL[SLV_IDX]. IDXW = clog2(REG_COUNT).
- Decode of latched address: hit = PADDR[ADDR_WIDTH-1:IDXW+2] == BASE_ADDR[ADDR_WIDTH-1:IDXW+2]; aligned = PADDR[1:0]==0; idx = PADDR[IDXW+1:2].
- err = !hit | !aligned | (write & idx==0). Register 0 is read-only, returns ID_VALUE.
- FSM states IDLE, WAIT, DONE:
  - IDLE: on edge with sel=1, PENABLE=0 (setup phase): latch PADDR/PWRITE/PWDATA, load wcnt=WAIT_CYCLES; go to DONE if WAIT_CYCLES==0 else WAIT. sel=1 with PENABLE=1 in IDLE is ignored (no setup seen).
  - WAIT: wcnt decrements each edge; on edge where wcnt==1 go to DONE.
  - DONE: PREADY=1. On edge with sel & PENABLE: write commits (if !err and PWRITE), go to IDLE.
  - Any state other than IDLE with sel=0 on an edge: abort, go to IDLE, no write, outputs cleared.
- On entry to DONE: PRDATA = (read & !err) ? reg[idx] (ID_VALUE if idx 0) : 0; PSLVERR = err.
- In IDLE and WAIT: PREADY=0, PSLVERR=0, PRDATA=0.
- Errored write leaves register bank unchanged. Errored read returns 0.

## Timing
- Reset (PRESET=1, async): state IDLE, PREADY=0, PRDATA=0, PSLVERR=0, reg[1..REG_COUNT-1]=0; wcnt=0. Takes effect immediately, including mid-transfer; transfer discarded.
- Setup sampled at edge T0; PREADY rises after edge T0+WAIT_CYCLES; transfer completes at edge T0+WAIT_CYCLES+1. Zero-wait: PREADY high in first access cycle.
- PREADY falls after the completion edge (one-cycle pulse per transfer).
- Written value visible to a read whose setup is sampled at the completion edge or later (back-to-back, no idle cycle required).
- PSEL/PADDR/PWRITE/PWDATA changes during WAIT/DONE are ignored except sel=0 (abort); latched values are used.
- Other PSEL bits never affect the block.

## Test plan
- Reset then zero-wait read of 0x1000 -> PREADY high in first access cycle, PRDATA=0xA9B0_0001, PSLVERR=0.
- WAIT_CYCLES=3: write 0xDEAD_BEEF to 0x1008, read back -> PREADY high 3 cycles after setup edge each time, readback 0xDEAD_BEEF, PSLVERR=0.
- Errors: write 0x1000, read 0x1002, read 0x2000 -> each PSLVERR=1 with PREADY, PRDATA=0; reg0 still reads ID_VALUE.
- Back-to-back write 0x1004=0x1234_5678 then read 0x1004 with no idle cycle -> read returns 0x1234_5678.
- PSEL[SLV_IDX+1] transfer to 0x1004 -> PREADY stays 0, register unchanged; PSEL dropped during WAIT -> return to IDLE, no write.
- PRESET asserted in WAIT of a write to 0x100C -> outputs 0 immediately; after release 0x100C reads 0.
